// File: rtl/bbox_stream_pkg.sv
// Shared types and helpers for the triangle bounding-box stream unit.
// The helpers work on MAX_W-wide values; callers size-cast to their own widths.
package bbox_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        CLAMP,
        DONE
    } state_t;

    localparam int VERTS = 3;
    localparam int MAX_W = 32;

    // Vertex idx of a packed {x0,y0,x1,y1,x2,y2} triangle, returned as {x,y} in the LSBs.
    function automatic logic [2*MAX_W-1:0] unpack_vertex(
        input logic [VERTS*2*MAX_W-1:0] tri_v,
        input int                       coord_w,
        input int                       idx
    );
        return (2*MAX_W)'(tri_v >> ((VERTS - 1 - idx) * 2 * coord_w));
    endfunction

    function automatic logic signed [MAX_W-1:0] floor_int(
        input logic signed [MAX_W-1:0] coord,
        input int                      frac_w
    );
        return coord >>> frac_w;
    endfunction

endpackage

// File: rtl/bbox_stream_if.sv
// Triangle-in / bounding-box-out handshake bundle for bbox_stream.
interface bbox_stream_if #(
    parameter int COORD_W = 16,
    parameter int PIX_W   = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [6*COORD_W-1:0]   in_tri;
    logic                   out_valid;
    logic                   out_ready;
    logic [PIX_W-1:0]       x_min;
    logic [PIX_W-1:0]       x_max;
    logic [PIX_W-1:0]       y_min;
    logic [PIX_W-1:0]       y_max;
    logic                   culled;

    modport master (
        output in_valid, in_tri, out_ready,
        input  in_ready, out_valid, x_min, x_max, y_min, y_max, culled
    );

    modport slave (
        input  in_valid, in_tri, out_ready,
        output in_ready, out_valid, x_min, x_max, y_min, y_max, culled
    );
endinterface

// File: rtl/bbox_stream_axis_clamp.sv
// One axis of the bounding box: floor to integer pixels, clamp to 0..limit,
// and flag the span as entirely off-screen.
module bbox_axis_clamp
    import bbox_pkg::*;
#(
    parameter int COORD_W = 16,
    parameter int FRAC_W  = 4,
    parameter int INT_W   = 13,
    parameter int PIX_W   = 8
) (
    input  logic signed [COORD_W-1:0] raw_min_i,
    input  logic signed [COORD_W-1:0] raw_max_i,
    input  logic signed [INT_W-1:0]   limit_i,
    output logic [PIX_W-1:0]          min_o,
    output logic [PIX_W-1:0]          max_o,
    output logic                      off_o
);

    logic signed [INT_W-1:0] int_min;
    logic signed [INT_W-1:0] int_max;
    logic signed [INT_W-1:0] cl_min;
    logic signed [INT_W-1:0] cl_max;

    function automatic logic signed [INT_W-1:0] clamp_to(
        input logic signed [INT_W-1:0] v,
        input logic signed [INT_W-1:0] lim
    );
        if (v[INT_W-1]) begin
            return '0;
        end else if (v > lim) begin
            return lim;
        end
        return v;
    endfunction

    assign int_min = INT_W'(floor_int(MAX_W'(raw_min_i), FRAC_W));
    assign int_max = INT_W'(floor_int(MAX_W'(raw_max_i), FRAC_W));

    assign off_o  = int_max[INT_W-1] || (int_min > limit_i);
    assign cl_min = clamp_to(int_min, limit_i);
    assign cl_max = clamp_to(int_max, limit_i);
    assign min_o  = PIX_W'(cl_min);
    assign max_o  = PIX_W'(cl_max);

endmodule

// File: rtl/bbox_stream.sv
// Triangle setup: scans three vertices, then registers the clamped pixel bounding box.
//   state | meaning
//   IDLE  | ready for a triangle (in_ready=1)
//   SCAN  | one vertex per cycle into running min/max, vtx_cnt 0..2
//   CLAMP | floor, clamp and cull; outputs registered
//   DONE  | out_valid held until out_ready
module bbox_stream
    import bbox_pkg::*;
#(
    parameter int COORD_W  = 16,
    parameter int FRAC_W   = 4,
    parameter int SCREEN_W = 256,
    parameter int SCREEN_H = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    bbox_stream_if.slave  bus
);

    localparam int PIX_W = $clog2(SCREEN_W > SCREEN_H ? SCREEN_W : SCREEN_H);
    localparam int INT_A = COORD_W - FRAC_W + 1;
    localparam int INT_W = (INT_A > PIX_W + 2) ? INT_A : PIX_W + 2;
    localparam int TRI_W = VERTS * 2 * COORD_W;
    localparam logic signed [INT_W-1:0] LIM_X = INT_W'(SCREEN_W - 1);
    localparam logic signed [INT_W-1:0] LIM_Y = INT_W'(SCREEN_H - 1);

    state_t                    state_q;
    logic [TRI_W-1:0]          tri_q;
    logic [1:0]                vtx_cnt_q;
    logic signed [COORD_W-1:0] min_x_q, max_x_q, min_y_q, max_y_q;
    logic signed [COORD_W-1:0] min_x_d, max_x_d, min_y_d, max_y_d;
    logic                      in_ready_q, out_valid_q, culled_q;
    logic [PIX_W-1:0]          x_min_q, x_max_q, y_min_q, y_max_q;

    logic [2*COORD_W-1:0]      vtx;
    logic signed [COORD_W-1:0] vx, vy;
    logic [PIX_W-1:0]          cx_min, cx_max, cy_min, cy_max;
    logic                      off_x, off_y;

    // The vertex being scanned always sits in the top slot of the shift register.
    assign vtx = (2*COORD_W)'(unpack_vertex((VERTS*2*MAX_W)'(tri_q), COORD_W, 0));
    assign vx  = signed'(vtx[2*COORD_W-1:COORD_W]);
    assign vy  = signed'(vtx[COORD_W-1:0]);

    always_comb begin
        min_x_d = min_x_q;
        max_x_d = max_x_q;
        min_y_d = min_y_q;
        max_y_d = max_y_q;
        if (vtx_cnt_q == 2'd0) begin
            min_x_d = vx;
            max_x_d = vx;
            min_y_d = vy;
            max_y_d = vy;
        end else begin
            if (vx < min_x_q) min_x_d = vx;
            if (vx > max_x_q) max_x_d = vx;
            if (vy < min_y_q) min_y_d = vy;
            if (vy > max_y_q) max_y_d = vy;
        end
    end

    bbox_axis_clamp #(
        .COORD_W (COORD_W),
        .FRAC_W  (FRAC_W),
        .INT_W   (INT_W),
        .PIX_W   (PIX_W)
    ) u_clamp_x (
        .raw_min_i (min_x_q),
        .raw_max_i (max_x_q),
        .limit_i   (LIM_X),
        .min_o     (cx_min),
        .max_o     (cx_max),
        .off_o     (off_x)
    );

    bbox_axis_clamp #(
        .COORD_W (COORD_W),
        .FRAC_W  (FRAC_W),
        .INT_W   (INT_W),
        .PIX_W   (PIX_W)
    ) u_clamp_y (
        .raw_min_i (min_y_q),
        .raw_max_i (max_y_q),
        .limit_i   (LIM_Y),
        .min_o     (cy_min),
        .max_o     (cy_max),
        .off_o     (off_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tri_q       <= '0;
            vtx_cnt_q   <= '0;
            min_x_q     <= '0;
            max_x_q     <= '0;
            min_y_q     <= '0;
            max_y_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            culled_q    <= 1'b0;
            x_min_q     <= '0;
            x_max_q     <= '0;
            y_min_q     <= '0;
            y_max_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        tri_q      <= bus.in_tri;
                        vtx_cnt_q  <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= SCAN;
                    end
                end
                SCAN: begin
                    min_x_q   <= min_x_d;
                    max_x_q   <= max_x_d;
                    min_y_q   <= min_y_d;
                    max_y_q   <= max_y_d;
                    tri_q     <= tri_q << (2 * COORD_W);
                    vtx_cnt_q <= vtx_cnt_q + 2'd1;
                    if (vtx_cnt_q == 2'd2) begin
                        state_q <= CLAMP;
                    end
                end
                CLAMP: begin
                    // A culled box reports all-zero bounds rather than clamped ones.
                    culled_q    <= off_x || off_y;
                    x_min_q     <= (off_x || off_y) ? '0 : cx_min;
                    x_max_q     <= (off_x || off_y) ? '0 : cx_max;
                    y_min_q     <= (off_x || off_y) ? '0 : cy_min;
                    y_max_q     <= (off_x || off_y) ? '0 : cy_max;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.x_min     = x_min_q;
    assign bus.x_max     = x_max_q;
    assign bus.y_min     = y_min_q;
    assign bus.y_max     = y_max_q;
    assign bus.culled    = culled_q;

endmodule

// File: tb/tb_bbox_stream.sv
// Bench for bbox_stream: vector table through a scoreboard, plus latency,
// backpressure and mid-scan reset sequences.
module tb_bbox_stream;

    logic clk;
    logic rst_n;

    bbox_stream_if #(.COORD_W(16), .PIX_W(8)) bus ();

    bbox_stream #(
        .COORD_W  (16),
        .FRAC_W   (4),
        .SCREEN_W (256),
        .SCREEN_H (256)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Coordinates in 1/16 pixel units; expected bounds are hand-derived.
    typedef struct {
        int x0, y0, x1, y1, x2, y2;
        int xmin, xmax, ymin, ymax;
        int culled;
    } vec_t;

    typedef struct packed {
        logic [7:0] xmin, xmax, ymin, ymax;
        logic       culled;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic vec_t mk(input int x0, y0, x1, y1, x2, y2,
                                input int xmin, xmax, ymin, ymax, input int cul);
        vec_t v;
        v.x0 = x0; v.y0 = y0; v.x1 = x1; v.y1 = y1; v.x2 = x2; v.y2 = y2;
        v.xmin = xmin; v.xmax = xmax; v.ymin = ymin; v.ymax = ymax; v.culled = cul;
        return v;
    endfunction

    function automatic logic [95:0] pack_tri(input vec_t v);
        return {16'(v.x0), 16'(v.y0), 16'(v.x1), 16'(v.y1), 16'(v.x2), 16'(v.y2)};
    endfunction

    function automatic exp_t exp_of(input vec_t v);
        exp_t e;
        e.xmin = 8'(v.xmin); e.xmax = 8'(v.xmax);
        e.ymin = 8'(v.ymin); e.ymax = 8'(v.ymax);
        e.culled = 1'(v.culled);
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL unexpected_out: got=out_valid with empty scoreboard at %0t", $time);
            end else begin
                mon_e = sb.pop_front();
                check("x_min",  32'(bus.x_min),  32'(mon_e.xmin));
                check("x_max",  32'(bus.x_max),  32'(mon_e.xmax));
                check("y_min",  32'(bus.y_min),  32'(mon_e.ymin));
                check("y_max",  32'(bus.y_max),  32'(mon_e.ymax));
                check("culled", 32'(bus.culled), 32'(mon_e.culled));
            end
        end
    end

    // Returns #1 after the accept edge with in_valid dropped and in_tri scrambled.
    task automatic send(input vec_t v);
        bit ok;
        ok = 1'b0;
        bus.in_tri   = pack_tri(v);
        bus.in_valid = 1'b1;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1'b1;
            @(posedge clk);
        end
        check("accept_timeout", 32'(ok), 32'd1);
        if (ok) sb.push_back(exp_of(v));
        #1;
        bus.in_valid = 1'b0;
        bus.in_tri   = {$urandom, $urandom, $urandom};
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && sb.size() > 0; n++) @(negedge clk);
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int lat;
        bit seen;

        vecs[0] = mk(168, 324, 480, 80, 252, 640,       10, 30, 5, 40, 0);
        vecs[1] = mk(-80, -48, 4800, 160, 800, 4320,    0, 255, 0, 255, 0);
        vecs[2] = mk(-320, 80, -160, 96, -24, 112,      0, 0, 0, 0, 1);
        vecs[3] = mk(4080, 0, 4160, 16, 4320, 32,       255, 255, 0, 2, 0);
        vecs[4] = mk(1614, 1601, 1614, 1601, 1614, 1601, 100, 100, 100, 100, 0);
        vecs[5] = mk(160, 4800, 320, 6400, 480, 4096,   0, 0, 0, 0, 1);
        vecs[6] = mk(-8, -4, 16, 16, 32, 8,             0, 2, 0, 1, 0);
        vecs[7] = mk(-48, -48, 0, 0, -16, -32,          0, 0, 0, 0, 0);

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_tri    = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_x_min",     32'(bus.x_min),     32'd0);
        check("rst_y_max",     32'(bus.y_max),     32'd0);
        check("rst_culled",    32'(bus.culled),    32'd0);

        // Latency: out_valid observed after the 4th edge past accept, one-cycle pulse.
        @(posedge clk); #1;
        send(vecs[0]);
        lat = 0;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("latency", 32'(lat), 32'd4);
        @(negedge clk);
        check("pulse_out_valid", 32'(bus.out_valid), 32'd0);
        check("pulse_in_ready",  32'(bus.in_ready),  32'd1);
        drain();

        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            send(vecs[i]);
            drain();
        end

        // Backpressure with a second triangle waiting on the input.
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        send(vecs[1]);
        bus.in_tri   = pack_tri(vecs[6]);
        bus.in_valid = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        check("bp_out_valid_rise", 32'(seen), 32'd1);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_in_ready",  32'(bus.in_ready),  32'd0);
            check("bp_x_max",     32'(bus.x_max),     32'd255);
            check("bp_y_max",     32'(bus.y_max),     32'd255);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_idle_in_ready",  32'(bus.in_ready),  32'd1);
        check("bp_idle_out_valid", 32'(bus.out_valid), 32'd0);
        sb.push_back(exp_of(vecs[6]));
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_tri   = {$urandom, $urandom, $urandom};
        @(negedge clk);
        check("bp_second_accepted", 32'(bus.in_ready), 32'd0);
        drain();

        // Reset during SCAN with vtx_cnt=1; the aborted triangle must leave no trace.
        @(posedge clk); #1;
        send(vecs[2]);
        @(posedge clk); #1;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("mid_rst_x_min",     32'(bus.x_min),     32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rel_out_valid", 32'(bus.out_valid), 32'd0);
        check("rel_in_ready",  32'(bus.in_ready),  32'd1);
        check("rel_y_min",     32'(bus.y_min),     32'd0);
        @(posedge clk); #1;
        send(vecs[0]);
        drain();
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
